mic_frame_aligner: RTL and testbench
====================================

# mic_frame_aligner

Upstream front end of the 16-channel summing adder (`adder_16x23bit`) in the delay-and-sum beamformer. It takes one 23-bit microphone sample per cycle, time-multiplexed by channel 0..15, and assembles each set of 16 samples into a frame. Each channel passes through its own programmable-depth circular delay line. When a frame completes, the block presents 16 time-aligned lanes in one cycle, and these drive the adder inputs directly.

## Interface
- `DW`, 23: sample width per lane.
- `NCH`, 16: channel count, fixed at 16; `in_ch` is 4 bits.
- `DEPTH`, 32: delay-line depth per channel; maximum delay is `DEPTH-1` = 31 frames.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample strobe; idle cycles between samples are allowed.
- `in_ch`  in  4  channel index of `in_data`.
- `in_data`  in  DW  sample.
- `cfg_we`  in  1  delay register write strobe.
- `cfg_ch`  in  4  channel whose delay is written.
- `cfg_delay`  in  5  delay in frames, 0..31.
- `err_clr`  in  1  clears `err_seq`.
- `out_valid`  out  1  one-cycle pulse per completed frame.
- `out_flat`  out  NCH*DW  aligned lanes; lane i occupies bits [DW*i+DW-1 : DW*i].
- `err_seq`  out  1  sticky channel-sequence error flag.

## Operation
- Expected-channel counter `exp_ch` starts at 0. A sample with `in_valid=1` and `in_ch==exp_ch` is accepted:
  - written to delay line `in_ch` at shared pointer `wr_ptr`;
  - `exp_ch` increments.
- Sequence violation (`in_ch != exp_ch`):
  - partial frame is discarded; `err_seq` is set;
  - if `in_ch==0`, the sample is accepted as the start of a new frame and `exp_ch` becomes 1;
  - otherwise the sample is dropped and `exp_ch` becomes 0.
  - Writes already made for the discarded frame are overwritten by the next frame, because `wr_ptr` has not advanced.
- Frame completion is the acceptance of ch15. For each lane i, with d = `delay[i]`, the block reads entry `(wr_ptr - d) mod 32` of delay line i.
  - Lane 15 with d=0 forwards `in_data` in place of the RAM read, since that write occurs in the same cycle.
  - If d > `fcnt`, the lane outputs 0 (warm-up masking).
  - The read values are registered into `out_flat`. `wr_ptr` increments mod 32, wrapping 31→0. `fcnt` increments, saturating at 31. `exp_ch` returns to 0.
- `fcnt` counts completed frames since reset, saturating at 31. Memory contents are never reset; warm-up masking alone guarantees zero output for unwritten history.
- Delay registers:
  - `cfg_we` writes `delay[cfg_ch] = cfg_delay`.
  - A write in the same cycle as frame completion is not seen by that frame, which uses the old value; it applies from the next frame.
- `err_seq` set has priority over `err_clr` in the same cycle.
- Unsigned/two's-complement agnostic: data is moved verbatim, with no arithmetic on samples.

## Timing
- Latency: `out_valid` rises the cycle after ch15 is accepted and lasts exactly one cycle.
- `out_flat` holds its value between pulses.
- No backpressure: the downstream adder is combinational, so the input is always ready.
- Maximum frame rate is one frame per 16 cycles.
- Reset values:
  - `out_valid`=0, `out_flat`=0, `err_seq`=0;
  - `exp_ch`=0, `wr_ptr`=0, `fcnt`=0;
  - all `delay[i]`=0.
- Reset mid-frame discards the partial frame. The first frame after reset is frame 0, so any lane with d>0 outputs 0.
- `rst` has priority over all inputs in the same cycle.

## Test plan
- **Basic frame:**
  - Stimulus: after reset, all delays 0; feed ch0..15 with data = ch+1.
  - Response: `out_valid` pulses once, 1 cycle after ch15; lane i = i+1; downstream sum = 136.
- **Delay with warm-up:**
  - Stimulus: delay[3]=2; frames n=0..5 with data = 16n+ch.
  - Response: lane 3 = 0 for n=0,1, then 16(n-2)+3; other lanes = 16n+ch.
- **Sequence error:**
  - Stimulus: send ch0..4, then ch7.
  - Response: `err_seq`=1, no `out_valid`.
  - Stimulus: then a full ordered frame with data 0x100+ch.
  - Response: lanes = 0x100+i; `wr_ptr` advanced once.
  - Stimulus: `err_clr`.
  - Response: `err_seq`=0.
- **Wrap-around:**
  - Stimulus: delay[0]=31, delay[15]=0; 40 frames.
  - Response: lane 0 = 0 for n<31, then the frame n-31 value, including across the `wr_ptr` 31→0 wrap; lane 15 always equals the current sample (forwarding path).
- **Config collision:**
  - Stimulus: `cfg_we` (ch2, delay 1) in the same cycle as ch15 acceptance.
  - Response: that frame's lane 2 uses delay 0; the next frame's lane 2 uses delay 1.
- **Reset mid-frame:**
  - Stimulus: assert `rst` after ch0..7.
  - Response: outputs 0; delays back to 0.
  - Stimulus: then a full frame.
  - Response: correct lanes; `fcnt` restarted.

Source files
------------

// File: rtl/mic_frame_aligner.sv
// mic_frame_aligner
//   Collects a time-multiplexed stream of microphone samples (channel 0..15,
//   one per cycle at most) into frames. Each channel is passed through its own
//   circular delay line of programmable depth. On the cycle after channel 15
//   is accepted, all 16 delayed lanes are presented together for one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   sample strobe
//   in_ch      channel index of in_data (must run 0,1,..,15)
//   in_data    DW-bit sample, moved verbatim
//   cfg_we     delay register write strobe
//   cfg_ch     channel whose delay is written
//   cfg_delay  delay in frames, 0..DEPTH-1
//   err_clr    clears err_seq
//   out_valid  one-cycle pulse per completed frame
//   out_flat   aligned lanes, lane i at [DW*i +: DW]; held between pulses
//   err_seq    sticky channel-sequence error flag
module mic_frame_aligner #(
  parameter int DW    = 23,
  parameter int NCH   = 16,
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        in_ch,
  input  logic [DW-1:0]     in_data,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [4:0]        cfg_delay,
  input  logic              err_clr,
  output logic              out_valid,
  output logic [NCH*DW-1:0] out_flat,
  output logic              err_seq
);

  // Frame counter saturates so that a delay of up to 31 stays unmasked forever
  // once enough history exists.
  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  logic [3:0]        exp_ch;
  logic [4:0]        wr_ptr;
  logic [4:0]        fcnt;
  logic [4:0]        delay   [NCH];
  logic [DW-1:0]     mem     [NCH][DEPTH];
  logic [4:0]        rd_addr [NCH];

  logic              seq_err;
  logic              accept;
  logic              complete;
  logic [NCH*DW-1:0] lanes_p0;
  logic [NCH*DW-1:0] lanes_p1;
  logic              vld_p1;

  // ---- stage p0: sequence check, delay-line write, lane gather ----
  always_comb begin
    seq_err  = in_valid && (in_ch != exp_ch);
    // A channel-0 sample is always accepted: it either continues the expected
    // order or restarts a frame after a sequence violation.
    accept   = in_valid && ((in_ch == exp_ch) || (in_ch == 4'd0));
    complete = accept && (in_ch == 4'(NCH-1));
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      rd_addr[i] = wr_ptr - delay[i];
    end
  end

  always_comb begin
    lanes_p0 = '0;
    for (int i = 0; i < NCH; i++) begin
      if (delay[i] > fcnt) begin
        // Not enough frames since reset: history is unwritten, output zero.
        lanes_p0[i*DW +: DW] = '0;
      end else if ((i == NCH-1) && (delay[i] == 5'd0)) begin
        // The last channel's write lands in this same cycle; forward it.
        lanes_p0[i*DW +: DW] = in_data;
      end else begin
        lanes_p0[i*DW +: DW] = mem[i][rd_addr[i]];
      end
    end
  end

  // Delay-line storage has no reset; warm-up masking hides stale contents.
  // A discarded partial frame is simply overwritten because wr_ptr is unchanged.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[in_ch][wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_ch  <= 4'd0;
      wr_ptr  <= 5'd0;
      fcnt    <= 5'd0;
      err_seq <= 1'b0;
      vld_p1  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        delay[i] <= 5'd0;
      end
    end else begin
      if (seq_err) begin
        exp_ch <= (in_ch == 4'd0) ? 4'd1 : 4'd0;
      end else if (accept) begin
        exp_ch <= exp_ch + 4'd1;
      end
      if (complete) begin
        wr_ptr <= wr_ptr + 5'd1;
        fcnt   <= sat_inc5(fcnt);
      end
      vld_p1 <= complete;
      if (seq_err) begin
        err_seq <= 1'b1;
      end else if (err_clr) begin
        err_seq <= 1'b0;
      end
      // Non-blocking update: a frame completing this cycle still sees the old delay.
      if (cfg_we) begin
        delay[cfg_ch] <= cfg_delay;
      end
    end
  end

  // ---- stage p1: registered aligned lanes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_p1 <= '0;
    end else if (complete) begin
      lanes_p1 <= lanes_p0;
    end
  end

  assign out_valid = vld_p1;
  assign out_flat  = lanes_p1;

endmodule

// File: tb/tb_mic_frame_aligner.sv
module tb_mic_frame_aligner;
  localparam int DW  = 23;
  localparam int NCH = 16;
  localparam int FW  = NCH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [3:0]    in_ch;
  logic [DW-1:0] in_data;
  logic          cfg_we;
  logic [3:0]    cfg_ch;
  logic [4:0]    cfg_delay;
  logic          err_clr;
  logic          out_valid;
  logic [FW-1:0] out_flat;
  logic          err_seq;

  mic_frame_aligner #(.DW(DW), .NCH(NCH), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .err_clr(err_clr),
    .out_valid(out_valid), .out_flat(out_flat), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: list of completed frames since reset plus delay table.
  logic [FW-1:0] hist [$];
  int            mdelay [NCH];
  logic [DW-1:0] cur [NCH];
  logic [FW-1:0] last_exp;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [31:0] t;
    t = $urandom();
    return t[DW-1:0];
  endfunction

  // Expected output for the newest frame in hist: frame n, lane i with delay d
  // shows frame n-d, or zero if fewer than d frames precede it (count saturates at 31).
  function automatic logic [FW-1:0] model_out();
    logic [FW-1:0] r;
    logic [FW-1:0] f;
    int n;
    int fc;
    r  = '0;
    n  = hist.size() - 1;
    fc = (n > 31) ? 31 : n;
    for (int i = 0; i < NCH; i++) begin
      if (mdelay[i] <= fc) begin
        f = hist[n - mdelay[i]];
        r[i*DW +: DW] = f[i*DW +: DW];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < NCH; i++) mdelay[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; err_clr = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_delay(input logic [3:0] ch, input logic [4:0] d);
    cfg_we = 1'b1; cfg_ch = ch; cfg_delay = d;
    step();
    cfg_we = 1'b0;
    mdelay[ch] = int'(d);
  endtask

  task automatic send_one(input logic [3:0] ch, input logic [DW-1:0] d);
    in_valid = 1'b1; in_ch = ch; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  // Sends cur[0..15] in order, optionally with idle gaps and a delay write
  // colliding with channel 15, then checks the output pulse and lanes.
  task automatic send_frame(input bit gaps, input bit col,
                            input logic [3:0] cch, input logic [4:0] cd);
    logic [FW-1:0] f;
    for (int ch = 0; ch < NCH; ch++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0; in_ch = 4'($urandom_range(0, 15)); in_data = rnd();
        step();
      end
      in_valid = 1'b1; in_ch = 4'(ch); in_data = cur[ch];
      if (col && ch == NCH-1) begin
        cfg_we = 1'b1; cfg_ch = cch; cfg_delay = cd;
      end
      step();
      in_valid = 1'b0; cfg_we = 1'b0;
      if (ch == 7) chk("no_vld_mid", FW'(out_valid), FW'(1'b0));
    end
    for (int i = 0; i < NCH; i++) f[i*DW +: DW] = cur[i];
    hist.push_back(f);
    last_exp = model_out();
    if (col) mdelay[cch] = int'(cd);
    chk("out_valid", FW'(out_valid), FW'(1'b1));
    chk("out_flat", out_flat, last_exp);
    step();
    chk("vld_pulse", FW'(out_valid), FW'(1'b0));
    chk("flat_hold", out_flat, last_exp);
  endtask

  initial begin
    int s;
    logic [DW-1:0] prev2;
    rst = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0; err_clr = 1'b0;
    model_reset();
    step();
    do_reset();
    chk("rst_valid", FW'(out_valid), FW'(1'b0));
    chk("rst_flat", out_flat, '0);
    chk("rst_err", FW'(err_seq), FW'(1'b0));

    // Basic frame: lane i = i+1, sum 136
    for (int i = 0; i < NCH; i++) cur[i] = DW'(i + 1);
    send_frame(1'b0, 1'b0, 4'd0, 5'd0);
    s = 0;
    for (int i = 0; i < NCH; i++) s += int'(last_exp[i*DW +: DW] & out_flat[i*DW +: DW]);
    chk("sum136", FW'(s), FW'(136));

    // Delay with warm-up
    do_reset();
    set_delay(4'd3, 5'd2);
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NCH; i++) cur[i] = DW'(16 * n + i);
      send_frame(n[0], 1'b0, 4'd0, 5'd0);
      chk("warm_lane3", FW'(out_flat[3*DW +: DW]), FW'((n < 2) ? 0 : 16 * (n - 2) + 3));
    end

    // Sequence error: ch0..4 then ch7
    for (int ch = 0; ch < 5; ch++) send_one(4'(ch), rnd());
    send_one(4'd7, rnd());
    chk("seq_err_set", FW'(err_seq), FW'(1'b1));
    step();
    chk("seq_no_vld", FW'(out_valid), FW'(1'b0));
    for (int i = 0; i < NCH; i++) cur[i] = DW'(32'h100 + i);
    send_frame(1'b0, 1'b0, 4'd0, 5'd0);
    chk("seq_err_sticky", FW'(err_seq), FW'(1'b1));
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("err_clr", FW'(err_seq), FW'(1'b0));
    // set beats clear in the same cycle
    err_clr = 1'b1; send_one(4'd5, rnd()); err_clr = 1'b0;
    chk("err_set_prio", FW'(err_seq), FW'(1'b1));
    err_clr = 1'b1; step(); err_clr = 1'b0;
    // ch0 mid-frame restarts the frame
    for (int ch = 0; ch < 4; ch++) send_one(4'(ch), rnd());
    for (int i = 0; i < NCH; i++) cur[i] = rnd();
    send_frame(1'b1, 1'b0, 4'd0, 5'd0);
    chk("restart_err", FW'(err_seq), FW'(1'b1));

    // Wrap-around: 40 frames, lane 0 delayed 31, lane 15 forwarded
    do_reset();
    set_delay(4'd0, 5'd31);
    set_delay(4'd15, 5'd0);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NCH; i++) cur[i] = rnd();
      send_frame(1'b1, 1'b0, 4'd0, 5'd0);
      chk("lane15_fwd", FW'(out_flat[15*DW +: DW]), FW'(cur[15]));
    end

    // Config collision on lane 2
    for (int i = 0; i < NCH; i++) cur[i] = rnd();
    prev2 = cur[2];
    send_frame(1'b0, 1'b1, 4'd2, 5'd1);
    chk("col_old_delay", FW'(out_flat[2*DW +: DW]), FW'(prev2));
    for (int i = 0; i < NCH; i++) cur[i] = rnd();
    send_frame(1'b1, 1'b0, 4'd0, 5'd0);
    chk("col_new_delay", FW'(out_flat[2*DW +: DW]), FW'(prev2));

    // Reset mid-frame, with err_seq set and a sample presented alongside rst
    send_one(4'd3, rnd());
    for (int ch = 0; ch < 8; ch++) send_one(4'(ch), rnd());
    rst = 1'b1; in_valid = 1'b1; in_ch = 4'd8; in_data = rnd();
    step();
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    chk("mid_rst_valid", FW'(out_valid), FW'(1'b0));
    chk("mid_rst_flat", out_flat, '0);
    chk("mid_rst_err", FW'(err_seq), FW'(1'b0));
    set_delay(4'd5, 5'd1);
    for (int i = 0; i < NCH; i++) cur[i] = rnd() | DW'(1);
    send_frame(1'b0, 1'b0, 4'd0, 5'd0);
    chk("post_rst_lane0", FW'(out_flat[0 +: DW]), FW'(cur[0]));
    chk("post_rst_lane5", FW'(out_flat[5*DW +: DW]), FW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
